// File: rtl/vliw_fetch_unit.sv
// vliw_fetch_unit -- instruction-fetch front end of the VLIW core.
// Owns the PC, issues in-order requests to instruction memory under a
// credit scheme (buffered + in-flight bundles never exceed FIFO_DEPTH),
// buffers returned bundles and hands them to decode. A redirect reloads
// the PC, flushes the buffer and drops every response still in flight.
// Optional feature macro: FETCH_PERF_EN (enables perf_bubble_cnt).
module vliw_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                BUNDLE_W   = 64,
    parameter int                PC_STEP    = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [BUNDLE_W-1:0] imem_rsp_data,
    output logic                bundle_valid,
    input  logic                bundle_ready,
    output logic [BUNDLE_W-1:0] bundle_data,
    output logic [ADDR_W-1:0]   bundle_pc,
    output logic [31:0]         perf_bubble_cnt
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]  CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

    // Program counter and the queue of PCs for requests still in flight.
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    tag_rd_ptr;
    logic [PTR_W-1:0]    tag_wr_ptr;

    // Bundle buffer presented to decode.
    logic [BUNDLE_W-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    fifo_count;

    // In-flight request count and number of stale responses still to discard.
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    drop;

    logic [CNT_W:0]      credits_used;
    logic                req_fire;
    logic                rsp_keep;
    logic                pop;

    // Every buffered or in-flight bundle holds one credit, so an arriving
    // response always finds a free buffer slot.
    assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !redirect_valid && (credits_used < CREDITS);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are kept only when no stale ones are pending and no flush
    // is happening this cycle.
    assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;

    assign bundle_valid   = (fifo_count != '0);
    assign pop            = bundle_valid && bundle_ready && !redirect_valid;
    assign bundle_data    = bundle_valid ? data_mem[rd_ptr] : '0;
    assign bundle_pc      = bundle_valid ? pc_mem[rd_ptr]   : '0;

    // PC advance on accept, reload on redirect; tag-queue pointers follow.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            tag_rd_ptr <= '0;
            tag_wr_ptr <= '0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc;
            tag_rd_ptr <= '0;
            tag_wr_ptr <= '0;
        end else begin
            if (req_fire) begin
                pc         <= pc + ADDR_W'(PC_STEP);
                tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
            end
            if (rsp_keep) begin
                tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage writes: request PC into the tag queue, bundle plus its tag into the buffer.
    // NOTE: storage arrays carry no reset; validity is held by the reset
    // pointers and counters, and the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_ptr] <= pc;
        end
        if (rsp_keep) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= tag_mem[tag_rd_ptr];
        end
    end

    // Bundle buffer pointers and occupancy; push and pop may coincide at any fill level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect_valid) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (rsp_keep) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({rsp_keep, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // In-flight tracking; a redirect turns everything still in flight into drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            drop        <= '0;
        end else begin
            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (redirect_valid) begin
                drop <= outstanding - CNT_W'(imem_rsp_valid);
            end else if (imem_rsp_valid && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt;

    // Count decode bubbles (nothing to hand over, no flush), saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!bundle_valid && !redirect_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign perf_bubble_cnt = bubble_cnt;
`else
    assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// tb_vliw_fetch_unit -- self-checking bench for vliw_fetch_unit.
// A behavioural instruction memory answers requests in order after a
// random latency; a queue-based model predicts request validity, the
// request address stream, buffered bundles and the delivered PC sequence.
module tb_vliw_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [31:0] STEP  = 32'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [63:0] imem_rsp_data;
    logic        bundle_valid;
    logic        bundle_ready;
    logic [63:0] bundle_data;
    logic [31:0] bundle_pc;
    logic [31:0] perf_bubble_cnt;

    vliw_fetch_unit #(
        .ADDR_W    (32),
        .BUNDLE_W  (64),
        .PC_STEP   (8),
        .FIFO_DEPTH(DEPTH),
        .RESET_PC  (RPC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .bundle_valid   (bundle_valid),
        .bundle_ready   (bundle_ready),
        .bundle_data    (bundle_data),
        .bundle_pc      (bundle_pc),
        .perf_bubble_cnt(perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pending[$];     // requests accepted by memory, not yet answered
    logic [31:0] exp_fifo[$];    // PCs of bundles that should sit in the buffer
    logic [31:0] acc_log[$];     // addresses accepted, for directed checks
    int          stale_cnt;      // in-flight responses that belong to a flushed stream
    int          cyc;
    int          total;
    int          bad;
    int          acc_cnt;
    int          del_cnt;
    int          ready_pct;
    int          bready_pct;
    int          lat_lo;
    int          lat_hi;
    logic [31:0] next_req_pc;
    logic [31:0] next_del_pc;
    logic [31:0] exp_perf;
    bit          rd_req;
    logic [31:0] rd_pc_req;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hC3A5_5A3C, ~a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        exp_fifo.delete();
        stale_cnt   = 0;
        cyc         = 0;
        next_req_pc = RPC;
        next_del_pc = RPC;
        exp_perf    = 32'd0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model over the rising edge.
    task automatic cycle();
        bit          exp_rv;
        bit          exp_bv;
        bit          acc;
        bit          rsp;
        bit          pp;
        bit          rd;
        logic [31:0] rpc;
        logic [31:0] acc_addr;
        req_t        h;
        req_t        r;

        redirect_valid = rd_req;
        redirect_pc    = rd_pc_req;
        rd_req         = 1'b0;
        imem_req_ready = (int'($urandom_range(99)) < ready_pct);
        bundle_ready   = (int'($urandom_range(99)) < bready_pct);
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = {$urandom, $urandom};
        end
        #1;

        exp_bv = (exp_fifo.size() != 0);
        exp_rv = !redirect_valid && ((exp_fifo.size() + pending.size()) < DEPTH);
        check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) check("req_addr", 64'(imem_req_addr), 64'(next_req_pc));
        check("bundle_valid", 64'(bundle_valid), 64'(exp_bv));
        if (exp_bv) begin
            check("bundle_pc", 64'(bundle_pc), 64'(exp_fifo[0]));
            check("bundle_data", bundle_data, mem_word(exp_fifo[0]));
        end
        check("perf_bubble_cnt", 64'(perf_bubble_cnt), 64'(exp_perf));

        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp      = imem_rsp_valid;
        pp       = bundle_valid && bundle_ready && !redirect_valid;
        rd       = redirect_valid;
        rpc      = redirect_pc;
        if (pp) begin
            check("deliver_pc", 64'(bundle_pc), 64'(next_del_pc));
            next_del_pc = next_del_pc + STEP;
            del_cnt++;
        end
        if (acc) begin
            acc_log.push_back(acc_addr);
            acc_cnt++;
        end

        @(posedge clk);
        if (rsp) begin
            h = pending.pop_front();
            if (stale_cnt > 0) stale_cnt--;
            else if (!rd) exp_fifo.push_back(h.addr);
        end
        if (pp && exp_fifo.size() > 0) void'(exp_fifo.pop_front());
        if (rd) begin
            exp_fifo.delete();
            stale_cnt   = pending.size();
            next_req_pc = rpc;
            next_del_pc = rpc;
        end
        if (acc) begin
            r.addr = acc_addr;
            r.due  = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
            pending.push_back(r);
            next_req_pc = next_req_pc + STEP;
        end
`ifdef FETCH_PERF_EN
        if (!exp_bv && !rd) exp_perf = exp_perf + 32'd1;
`endif
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_bundle_valid"}, 64'(bundle_valid), 64'd0);
        check({tag, "_bundle_data"}, bundle_data, 64'd0);
        check({tag, "_bundle_pc"}, 64'(bundle_pc), 64'd0);
        check({tag, "_perf"}, 64'(perf_bubble_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0; acc_cnt = 0; del_cnt = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        bundle_ready = 1'b0; rd_req = 1'b0; rd_pc_req = '0;
        ready_pct = 100; bready_pct = 100; lat_lo = 0; lat_hi = 0;
        model_reset();

        // Reset state, then sequential fetch from RESET_PC with an ideal memory.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        cycle();
        check("latency_n1", 64'(bundle_valid), 64'd0);
        cycle();
        check("latency_n2", 64'(bundle_valid), 64'd1);
        repeat (10) cycle();
        check("seq_addr0", 64'(acc_log[0]), 64'h100);
        check("seq_addr1", 64'(acc_log[1]), 64'h108);
        check("seq_addr2", 64'(acc_log[2]), 64'h110);

        // Backpressure: decode stalls, fetch stops after the credits run out.
        bready_pct = 0;
        rd_req = 1'b1; rd_pc_req = 32'h400;
        cycle();
        acc_cnt = 0;
        repeat (3) cycle();
        check("bp_head_pc_early", 64'(bundle_pc), 64'h400);
        repeat (7) cycle();
        check("bp_accepts", 64'(acc_cnt), 64'd4);
        check("bp_req_valid", 64'(imem_req_valid), 64'd0);
        check("bp_head_pc_late", 64'(bundle_pc), 64'h400);
        check("bp_head_data", bundle_data, mem_word(32'h400));
        bready_pct = 100;
        del_cnt = 0;
        repeat (8) cycle();
        check("bp_drain", 64'(del_cnt >= 4), 64'd1);

        // Redirect with at least two requests in flight.
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 20 && pending.size() < 2; i++) cycle();
        rd_req = 1'b1; rd_pc_req = 32'h2000;
        cycle();
        for (int i = 0; i < 20 && !bundle_valid; i++) cycle();
        check("rd2_valid", 64'(bundle_valid), 64'd1);
        check("rd2_first_pc", 64'(bundle_pc), 64'h2000);
        repeat (6) cycle();

        // Redirect colliding with a response and a pop.
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 30 && !(exp_fifo.size() > 0 && pending.size() >= 2 && pending[0].due <= cyc); i++)
            cycle();
        acc_cnt = 0;
        rd_req = 1'b1; rd_pc_req = 32'h3000;
        cycle();
        check("col_no_req", 64'(acc_cnt), 64'd0);
        check("col_empty", 64'(bundle_valid), 64'd0);
        repeat (10) cycle();

        // Address wrap at the top of the address space.
        lat_lo = 0; lat_hi = 0;
        rd_req = 1'b1; rd_pc_req = 32'hFFFF_FFF8;
        cycle();
        acc_log.delete();
        repeat (6) cycle();
        check("wrap_count", 64'(acc_log.size() >= 2), 64'd1);
        if (acc_log.size() >= 2) begin
            check("wrap_addr0", 64'(acc_log[0]), 64'hFFFF_FFF8);
            check("wrap_addr1", 64'(acc_log[1]), 64'h0);
        end

        // Randomized traffic: memory stalls, decode stalls, variable latency, redirects.
        ready_pct = 70; bready_pct = 60; lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(29) == 0) begin
                rd_req    = 1'b1;
                rd_pc_req = $urandom & 32'hFFFF_FFF8;
            end
            cycle();
        end

        // Asynchronous reset between clock edges with three requests in flight.
        ready_pct = 100; bready_pct = 0; lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 20 && pending.size() < 3; i++) cycle();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        bready_pct = 100; lat_lo = 0; lat_hi = 0;
        repeat (15) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
